// File: rtl/main_memory_wt_if.sv
// Cache<->memory request/response bundle for main_memory_wt.
// wr_word_mask exists only when MEM_WR_MASK_EN is defined.
interface main_memory_wt_if #(
  parameter int ADDR_W = 10
);
  logic              mem_req;
  logic              read_write_MEM;
  logic [ADDR_W-1:0] MEM_address;
  logic [127:0]      write_MEM_data;
`ifdef MEM_WR_MASK_EN
  logic [3:0]        wr_word_mask;
`endif
  logic [127:0]      read_MEM_data;
  logic              mem_ready;
  logic              mem_busy;

  modport master (
`ifdef MEM_WR_MASK_EN
    output wr_word_mask,
`endif
    output mem_req, read_write_MEM, MEM_address, write_MEM_data,
    input  read_MEM_data, mem_ready, mem_busy
  );

  modport slave (
`ifdef MEM_WR_MASK_EN
    input  wr_word_mask,
`endif
    input  mem_req, read_write_MEM, MEM_address, write_MEM_data,
    output read_MEM_data, mem_ready, mem_busy
  );
endinterface

// File: rtl/main_memory_wt.sv
// Block-organised main memory behind a write-through cache, fixed-latency responder.
// Optional per-word write mask enabled by defining MEM_WR_MASK_EN.
module main_memory_wt #(
  parameter int ADDR_W  = 10,
  parameter int BLOCK_W = 128,
  parameter int LATENCY = 4
) (
  input logic             clk,
  input logic             rst_n,
  main_memory_wt_if.slave bus
);
  localparam int IDX_W  = ADDR_W - 4;
  localparam int BLOCKS = 2 ** IDX_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_reg;
  logic [3:0]         cnt_reg;
  logic               op_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [BLOCK_W-1:0] wdata_reg;
  logic [3:0]         mask_reg;
  logic               ready_reg;
  logic               busy_reg;

  logic               access;
  logic               rd_en;
  logic [3:0]         req_mask;
  wire  [3:0]         wr_en;
  wire  [BLOCK_W-1:0] rd_data;
  wire                unused_offset = ^bus.MEM_address[3:0];

`ifdef MEM_WR_MASK_EN
  assign req_mask = bus.wr_word_mask;
`else
  assign req_mask = 4'hF;
`endif

  // Gating with rst_n keeps an aborted write from landing on the reset edge.
  assign access = (state_reg == WAIT) && (cnt_reg == 4'd0) && rst_n;
  assign rd_en  = access && !op_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.mem_req) begin
            op_reg    <= bus.read_write_MEM;
            idx_reg   <= bus.MEM_address[ADDR_W-1:4];
            wdata_reg <= bus.write_MEM_data;
            mask_reg  <= req_mask;
            cnt_reg   <= 4'(LATENCY - 1);
            busy_reg  <= 1'b1;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            ready_reg <= 1'b1;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // One 32-bit bank per word so the mask maps onto independent write enables.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      logic [31:0] bank [0:BLOCKS-1] = '{default: '0};
      logic [31:0] word_reg;

      assign wr_en[gi] = access && op_reg && mask_reg[gi];

      always_ff @(posedge clk) begin
        if (wr_en[gi]) begin
          bank[idx_reg] <= wdata_reg[32*gi +: 32];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          word_reg <= '0;
        end else if (rd_en) begin
          word_reg <= bank[idx_reg];
        end
      end

      assign rd_data[32*gi +: 32] = word_reg;
    end
  endgenerate

  assign bus.read_MEM_data = rd_data;
  assign bus.mem_ready     = ready_reg;
  assign bus.mem_busy      = busy_reg;
endmodule
